// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWaitWord,
    StHold,
    StRelease,
    StDone,
    StFill
  } loader_state_e;

  localparam int unsigned WORD_BYTES          = 4;
  localparam logic [31:0] NOP_WORD            = 32'h0000_0000;
  localparam int unsigned DEFAULT_HOLD_CYCLES = 2;
  localparam int unsigned DEFAULT_PRE_CYCLES  = 10;

endpackage

// File: rtl/imem_program_loader_if.sv
// Valid/ready word stream feeding the program loader.
interface imem_program_loader_if;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;

  modport master (output word_valid, output word_data, output word_last, input word_ready);
  modport slave  (input word_valid, input word_data, input word_last, output word_ready);
endinterface

// File: rtl/imem_loader_hold_timer.sv
// Loadable down-counter; expired is high during the final counted cycle.
module imem_loader_hold_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] value,
  output logic             expired
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q <= Width'(1));

endmodule

// File: rtl/imem_program_loader.sv
// Streams a program into the CPU instruction memory, then releases CPU reset.
// Define IMEM_LOADER_NOP_FILL_EN to zero-fill the unused memory before release.
module imem_program_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int unsigned IMEM_WORDS  = 64,
  parameter int unsigned PRE_CYCLES  = DEFAULT_PRE_CYCLES,
  localparam int unsigned WlW        = $clog2(IMEM_WORDS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  imem_program_loader_if.slave       word_if,
  output logic                       cpu_rst,
  output logic                       initialize,
  output logic [31:0]                instruction_initialize_address,
  output logic [31:0]                instruction_initialize_data,
  output logic [WlW-1:0]             words_loaded,
  output logic                       busy,
  output logic                       overflow
);

  localparam int unsigned TimerMax = (HOLD_CYCLES > PRE_CYCLES) ? HOLD_CYCLES : PRE_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  loader_state_e state_q, state_d;
  logic          cpu_rst_q, cpu_rst_d, init_q, init_d;
  logic [31:0]   addr_q, addr_d, data_q, data_d;
  logic [WlW-1:0] wl_q, wl_d;
  logic          last_q, last_d, ovf_q, ovf_d;
  logic          tmr_load, tmr_expired, enter_tail;
  logic [TimerW-1:0] tmr_value;
`ifdef IMEM_LOADER_NOP_FILL_EN
  logic [WlW-1:0] fill_idx_q, fill_idx_d;
`endif

  imem_loader_hold_timer #(
    .Width (TimerW)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    cpu_rst_d  = cpu_rst_q;
    init_d     = init_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wl_d       = wl_q;
    last_d     = last_q;
    ovf_d      = ovf_q;
    tmr_load   = 1'b0;
    tmr_value  = TimerW'(HOLD_CYCLES);
    enter_tail = 1'b0;
`ifdef IMEM_LOADER_NOP_FILL_EN
    fill_idx_d = fill_idx_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StPre;
          cpu_rst_d = 1'b1;
          init_d    = 1'b1;
          addr_d    = '0;
          data_d    = '0;
          wl_d      = '0;
          last_d    = 1'b0;
          ovf_d     = 1'b0;
          tmr_load  = 1'b1;
          tmr_value = TimerW'(PRE_CYCLES);
        end
      end
      StPre: begin
        if (tmr_expired) state_d = StWaitWord;
      end
      StWaitWord: begin
        if (word_if.word_valid) begin
          if (wl_q == WlW'(IMEM_WORDS)) begin
            // Memory already full: drop the word and stop the load.
            ovf_d      = 1'b1;
            enter_tail = 1'b1;
          end else begin
            addr_d   = 32'(wl_q) * WORD_BYTES;
            data_d   = word_if.word_data;
            wl_d     = wl_q + WlW'(1);
            last_d   = word_if.word_last;
            tmr_load = 1'b1;
            state_d  = StHold;
          end
        end
      end
      StHold: begin
        if (tmr_expired) begin
          if (last_q) enter_tail = 1'b1;
          else        state_d    = StWaitWord;
        end
      end
`ifdef IMEM_LOADER_NOP_FILL_EN
      StFill: begin
        if (tmr_expired) begin
          if (fill_idx_q < WlW'(IMEM_WORDS)) begin
            addr_d     = 32'(fill_idx_q) * WORD_BYTES;
            data_d     = NOP_WORD;
            fill_idx_d = fill_idx_q + WlW'(1);
            tmr_load   = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end
      end
`endif
      StRelease: begin
        cpu_rst_d = 1'b0;
        init_d    = 1'b0;
        state_d   = StDone;
      end
      default: state_d = StIdle;
    endcase

    if (enter_tail) begin
`ifdef IMEM_LOADER_NOP_FILL_EN
      // One settling cycle in FILL before the first NOP write.
      state_d    = StFill;
      fill_idx_d = wl_d;
      tmr_load   = 1'b1;
      tmr_value  = TimerW'(1);
`else
      state_d = StRelease;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cpu_rst_q  <= 1'b1;
      init_q     <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      wl_q       <= '0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef IMEM_LOADER_NOP_FILL_EN
      fill_idx_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cpu_rst_q  <= cpu_rst_d;
      init_q     <= init_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wl_q       <= wl_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
`ifdef IMEM_LOADER_NOP_FILL_EN
      fill_idx_q <= fill_idx_d;
`endif
    end
  end

  assign word_if.word_ready             = (state_q == StWaitWord);
  assign busy                           = (state_q != StIdle) && (state_q != StDone);
  assign cpu_rst                        = cpu_rst_q;
  assign initialize                     = init_q;
  assign instruction_initialize_address = addr_q;
  assign instruction_initialize_data    = data_q;
  assign words_loaded                   = wl_q;
  assign overflow                       = ovf_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader (HOLD_CYCLES=2, PRE_CYCLES=3, IMEM_WORDS=4).
module tb_imem_program_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cpu_rst;
  logic        initialize;
  logic [31:0] addr;
  logic [31:0] data;
  logic [2:0]  wl;
  logic        busy;
  logic        ovf;
  int          n_assert;
  int          n_fail;

  imem_program_loader_if wif ();

  imem_program_loader #(
    .HOLD_CYCLES (2),
    .IMEM_WORDS  (4),
    .PRE_CYCLES  (3)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .start                          (start),
    .word_if                        (wif),
    .cpu_rst                        (cpu_rst),
    .initialize                     (initialize),
    .instruction_initialize_address (addr),
    .instruction_initialize_data    (data),
    .words_loaded                   (wl),
    .busy                           (busy),
    .overflow                       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_init"}, 32'(initialize), 32'd1);
    check({tag, "_addr"}, addr, 32'd0);
    check({tag, "_data"}, data, 32'd0);
    check({tag, "_wl"}, 32'(wl), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_ready"}, 32'(wif.word_ready), 32'd0);
  endtask

  // Pulse start, then walk through the 3-cycle PRE phase.
  task automatic do_start;
    start = 1'b1;
    step;
    start = 1'b0;
    check("pre_busy", 32'(busy), 32'd1);
    check("pre_cpu_rst", 32'(cpu_rst), 32'd1);
    check("pre_wl", 32'(wl), 32'd0);
    step;
    step;
    check("pre_ready", 32'(wif.word_ready), 32'd0);
    check("pre_addr", addr, 32'd0);
    check("pre_data", data, 32'd0);
    step;
  endtask

  // Offer one word while ready is expected high, then check both hold cycles.
  task automatic send_word(input logic [31:0] d, input logic l, input logic [31:0] exp_addr,
                           input int exp_wl);
    wif.word_valid = 1'b1;
    wif.word_data  = d;
    wif.word_last  = l;
    check("ready_wait", 32'(wif.word_ready), 32'd1);
    step;
    wif.word_valid = 1'b0;
    wif.word_last  = 1'b0;
    wif.word_data  = 32'hDEAD_BEEF;
    check("hold1_addr", addr, exp_addr);
    check("hold1_data", data, d);
    check("hold1_wl", 32'(wl), 32'(exp_wl));
    check("hold1_ready", 32'(wif.word_ready), 32'd0);
    step;
    check("hold2_addr", addr, exp_addr);
    check("hold2_data", data, d);
    step;
  endtask

  // Called in the cycle after the final hold (or the overflow handshake).
  task automatic release_check(input logic [31:0] last_addr, input logic [31:0] last_data,
                               input int exp_wl);
    logic [31:0] fa;
    logic [31:0] fd;
    fa = last_addr;
    fd = last_data;
`ifdef IMEM_LOADER_NOP_FILL_EN
    check("fill_entry_cpu_rst", 32'(cpu_rst), 32'd1);
    step;
    for (int a = exp_wl; a < 4; a++) begin
      for (int h = 0; h < 2; h++) begin
        check("fill_addr", addr, 32'(a * 4));
        check("fill_data", data, 32'd0);
        check("fill_init", 32'(initialize), 32'd1);
        step;
      end
      fa = 32'(a * 4);
      fd = 32'd0;
    end
`endif
    check("rel_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rel_init", 32'(initialize), 32'd1);
    check("rel_busy", 32'(busy), 32'd1);
    step;
    check("done_cpu_rst", 32'(cpu_rst), 32'd0);
    check("done_init", 32'(initialize), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_addr", addr, fa);
    check("done_data", data, fd);
    check("done_wl", 32'(wl), 32'(exp_wl));
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    rst            = 1'b0;
    start          = 1'b0;
    wif.word_valid = 1'b0;
    wif.word_data  = 32'h0;
    wif.word_last  = 1'b0;
    step;
    step;
    check_reset_vals("reset");
    rst = 1'b1;
    step;
    check("idle_cpu_rst", 32'(cpu_rst), 32'd1);

    // Three-word program.
    do_start;
    send_word(32'h0002_0820, 1'b0, 32'd0, 1);
    send_word(32'h3C01_FFFF, 1'b0, 32'd4, 2);
    send_word(32'h0022_0820, 1'b1, 32'd8, 3);
    release_check(32'd8, 32'h0022_0820, 3);
    check("p1_ovf", 32'(ovf), 32'd0);
    step;

    // Stalled source; a start pulse while busy must be ignored.
    do_start;
    send_word(32'h1111_0001, 1'b0, 32'd0, 1);
    for (int i = 0; i < 7; i++) begin
      start = (i == 2);
      check("stall_ready", 32'(wif.word_ready), 32'd1);
      check("stall_addr", addr, 32'd0);
      check("stall_data", data, 32'h1111_0001);
      check("stall_wl", 32'(wl), 32'd1);
      step;
    end
    start = 1'b0;
    check("stall_busy", 32'(busy), 32'd1);
    send_word(32'h2222_0002, 1'b1, 32'd4, 2);
    release_check(32'd4, 32'h2222_0002, 2);
    step;

    // Overflow: five words offered to a four-word memory, last never set.
    do_start;
    send_word(32'hA000_0000, 1'b0, 32'd0, 1);
    send_word(32'hA000_0001, 1'b0, 32'd4, 2);
    send_word(32'hA000_0002, 1'b0, 32'd8, 3);
    send_word(32'hA000_0003, 1'b0, 32'd12, 4);
    wif.word_valid = 1'b1;
    wif.word_data  = 32'hBAD0_0005;
    check("ovf_ready", 32'(wif.word_ready), 32'd1);
    step;
    wif.word_valid = 1'b0;
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_addr", addr, 32'd12);
    check("ovf_data", data, 32'hA000_0003);
    check("ovf_wl", 32'(wl), 32'd4);
    release_check(32'd12, 32'hA000_0003, 4);
    check("ovf_sticky", 32'(ovf), 32'd1);
    step;

    // Asynchronous reset during the hold of word 2, then a clean reload.
    do_start;
    send_word(32'hC000_0000, 1'b0, 32'd0, 1);
    wif.word_valid = 1'b1;
    wif.word_data  = 32'hC000_0001;
    step;
    wif.word_valid = 1'b0;
    check("mid_addr", addr, 32'd4);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    step;
    rst = 1'b1;
    step;
    do_start;
    send_word(32'hD000_0000, 1'b1, 32'd0, 1);
    release_check(32'd0, 32'hD000_0000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
